pulse_peak_detector: RTL and testbench

PULSE_PEAK_DETECTOR -- requirements
Module: pulse_peak_detector

---
 rtl/pulse_peak_detector_pkg.sv | 25 ++
 rtl/pulse_peak_detector_if.sv | 37 +++
 rtl/pulse_peak_detector_time_counter.sv | 20 ++
 rtl/pulse_peak_detector.sv | 197 +++++++++++++++++++
 tb/tb_pulse_peak_detector.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/pulse_peak_detector_pkg.sv
// Shared sizes, sample/state types and the width helper for the pulse peak
// detector slice.
package package_settings;

   localparam int SIZE_FILTER_DATA = 16;
   localparam int SIZE_DELAY       = 8;
   localparam int SIZE_TIMESTAMP   = 32;

   typedef logic signed [SIZE_FILTER_DATA-1:0] sample_t;

   typedef enum logic [1:0] {
      IDLE,
      RISE,
      FALL,
      HOLDOFF
   } state_t;

   function automatic logic [7:0] width_inc(
      input logic [7:0] w,
      input logic [7:0] max_w
   );
      return (w >= max_w) ? max_w : w + 8'd1;
   endfunction

endpackage

// File: rtl/pulse_peak_detector_if.sv
// Sample/config inputs and result bundle of the pulse peak detector.
// The detector uses the slave modport; the driver side uses master.
interface pulse_peak_detector_if;
   import package_settings::*;

   sample_t                   input_data;
   sample_t                   threshold;
   logic [SIZE_DELAY-1:0]     holdoff;
   logic                      output_valid;
   sample_t                   output_amplitude;
   logic [SIZE_TIMESTAMP-1:0] output_time;
   logic [7:0]                output_width;
   logic                      output_pileup;

   modport slave (
      input  input_data,
      input  threshold,
      input  holdoff,
      output output_valid,
      output output_amplitude,
      output output_time,
      output output_width,
      output output_pileup
   );

   modport master (
      output input_data,
      output threshold,
      output holdoff,
      input  output_valid,
      input  output_amplitude,
      input  output_time,
      input  output_width,
      input  output_pileup
   );

endinterface

// File: rtl/pulse_peak_detector_time_counter.sv
// Free-running wrapping sample stamp for the pulse peak detector.
module pulse_time_counter
   import package_settings::*;
#(
   parameter int W = SIZE_TIMESTAMP
) (
   input  logic         clk,
   input  logic         reset,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pulse_peak_detector.sv
// Threshold pulse detector reporting peak amplitude, stamp, width and pile-up.
// Define PULSE_PEAK_PILEUP_EN to enable the pile-up flag (tied 0 otherwise).
module pulse_peak_detector
   import package_settings::*;
#(
   parameter int MIN_WIDTH = 2,
   parameter int MAX_WIDTH = 255
) (
   input logic                  clk,
   input logic                  reset,
   pulse_peak_detector_if.slave bus
);

   localparam logic [7:0] MIN_W = 8'(MIN_WIDTH);
   localparam logic [7:0] MAX_W = 8'(MAX_WIDTH);

   logic [SIZE_TIMESTAMP-1:0] w_count;

   sample_t                   r_data;
   sample_t                   r_prev;
   logic [SIZE_TIMESTAMP-1:0] r_stamp;

   state_t                    r_state;
   sample_t                   r_peak;
   logic [SIZE_TIMESTAMP-1:0] r_peak_time;
   logic [7:0]                r_width;
   logic [SIZE_DELAY-1:0]     r_hold;

   logic                      r_valid;
   sample_t                   r_amp;
   logic [SIZE_TIMESTAMP-1:0] r_time;
   logic [7:0]                r_out_width;

   state_t                    w_nx_state;
   sample_t                   w_nx_peak;
   logic [SIZE_TIMESTAMP-1:0] w_nx_peak_time;
   logic [7:0]                w_nx_width;
   logic [SIZE_DELAY-1:0]     w_nx_hold;
   logic                      w_nx_valid;
   sample_t                   w_nx_amp;
   logic [SIZE_TIMESTAMP-1:0] w_nx_time;
   logic [7:0]                w_nx_out_width;
   logic                      w_above;
   logic                      w_end;

`ifdef PULSE_PEAK_PILEUP_EN
   logic r_pileup;
   logic r_out_pileup;
   logic w_nx_pileup;
   logic w_nx_out_pileup;
`endif

   pulse_time_counter #(
      .W(SIZE_TIMESTAMP)
   ) u_time (
      .clk  (clk),
      .reset(reset),
      .count(w_count)
   );

   assign w_above = (r_data > bus.threshold);

   always_comb begin
      w_nx_state     = r_state;
      w_nx_peak      = r_peak;
      w_nx_peak_time = r_peak_time;
      w_nx_width     = r_width;
      w_nx_hold      = r_hold;
      w_nx_valid     = 1'b0;
      w_nx_amp       = r_amp;
      w_nx_time      = r_time;
      w_nx_out_width = r_out_width;
      w_end          = 1'b0;
`ifdef PULSE_PEAK_PILEUP_EN
      w_nx_pileup     = r_pileup;
      w_nx_out_pileup = r_out_pileup;
`endif
      unique case (r_state)
         IDLE: begin
            if (w_above) begin
               w_nx_state     = RISE;
               w_nx_peak      = r_data;
               w_nx_peak_time = r_stamp;
               w_nx_width     = 8'd1;
`ifdef PULSE_PEAK_PILEUP_EN
               w_nx_pileup    = 1'b0;
`endif
            end
         end
         RISE: begin
            if (!w_above) begin
               w_end = 1'b1;
            end else begin
               w_nx_width = width_inc(r_width, MAX_W);
               if (r_data > r_peak) begin
                  w_nx_peak      = r_data;
                  w_nx_peak_time = r_stamp;
               end else if (r_data < r_peak) begin
                  w_nx_state = FALL;
               end
            end
         end
         FALL: begin
            if (!w_above) begin
               w_end = 1'b1;
            end else begin
               w_nx_width = width_inc(r_width, MAX_W);
               if (r_data > r_peak) begin
                  w_nx_peak      = r_data;
                  w_nx_peak_time = r_stamp;
               end
               // a renewed rise on the tail marks a second overlapping pulse
               if (r_data > r_prev) begin
                  w_nx_state  = RISE;
`ifdef PULSE_PEAK_PILEUP_EN
                  w_nx_pileup = 1'b1;
`endif
               end
            end
         end
         HOLDOFF: begin
            w_nx_hold = r_hold - 1'b1;
            if (r_hold <= 1) begin
               w_nx_state = IDLE;
            end
         end
         default: begin
            w_nx_state = IDLE;
         end
      endcase
      if (w_end) begin
         if (r_width >= MIN_W) begin
            w_nx_valid      = 1'b1;
            w_nx_amp        = r_peak;
            w_nx_time       = r_peak_time;
            w_nx_out_width  = r_width;
`ifdef PULSE_PEAK_PILEUP_EN
            w_nx_out_pileup = r_pileup;
`endif
         end
         w_nx_hold  = bus.holdoff;
         w_nx_state = (bus.holdoff == '0) ? IDLE : HOLDOFF;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data      <= '0;
         r_prev      <= '0;
         r_stamp     <= '0;
         r_state     <= IDLE;
         r_peak      <= '0;
         r_peak_time <= '0;
         r_width     <= '0;
         r_hold      <= '0;
         r_valid     <= 1'b0;
         r_amp       <= '0;
         r_time      <= '0;
         r_out_width <= '0;
      end else begin
         r_data      <= bus.input_data;
         r_prev      <= r_data;
         r_stamp     <= w_count;
         r_state     <= w_nx_state;
         r_peak      <= w_nx_peak;
         r_peak_time <= w_nx_peak_time;
         r_width     <= w_nx_width;
         r_hold      <= w_nx_hold;
         r_valid     <= w_nx_valid;
         r_amp       <= w_nx_amp;
         r_time      <= w_nx_time;
         r_out_width <= w_nx_out_width;
      end
   end

`ifdef PULSE_PEAK_PILEUP_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pileup     <= 1'b0;
         r_out_pileup <= 1'b0;
      end else begin
         r_pileup     <= w_nx_pileup;
         r_out_pileup <= w_nx_out_pileup;
      end
   end

   assign bus.output_pileup = r_out_pileup;
`else
   assign bus.output_pileup = 1'b0;
`endif

   assign bus.output_valid     = r_valid;
   assign bus.output_amplitude = r_amp;
   assign bus.output_time      = r_time;
   assign bus.output_width     = r_out_width;

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Scoreboard bench for pulse_peak_detector: directed pulses push expected
// results; a negedge monitor pops and compares on every output_valid strobe.
module tb_pulse_peak_detector;
   import package_settings::*;

`ifdef PULSE_PEAK_PILEUP_EN
   localparam logic PU = 1'b1;
`else
   localparam logic PU = 1'b0;
`endif

   typedef struct {
      longint amp;
      longint width;
      longint tstamp;
      longint pileup;
      int     cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   pulse_peak_detector_if bus ();

   pulse_peak_detector #(
      .MIN_WIDTH(2),
      .MAX_WIDTH(255)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   sidx  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset && bus.output_valid) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL stray_strobe: got strobe amp=%0d at cyc %0d want none",
                     bus.output_amplitude, cyc);
         end else begin
            e = sbq.pop_front();
            chk("amplitude", longint'(bus.output_amplitude), e.amp);
            chk("width", longint'(bus.output_width), e.width);
            chk("time", longint'(bus.output_time), e.tstamp);
            chk("pileup", longint'(bus.output_pileup), e.pileup);
            chk("latency_cyc", longint'(cyc), longint'(e.cyc));
         end
      end
   end

   task automatic send(input int v);
      bus.input_data = 16'(v);
      @(negedge clk);
      sidx++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send(0);
   endtask

   // tofs: index of the peak sample; eofs: index of the ending sample
   task automatic expect_pulse(input int amp, input int w, input int tofs,
                               input int eofs, input logic pu);
      exp_t e;
      e.amp    = longint'(amp);
      e.width  = longint'(w);
      e.tstamp = longint'(sidx + tofs);
      e.pileup = longint'(pu);
      e.cyc    = cyc + eofs + 2;
      sbq.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.input_data = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      sidx = 0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_valid"}, longint'(bus.output_valid), 0);
      chk({tag, "_amp"}, longint'(bus.output_amplitude), 0);
      chk({tag, "_time"}, longint'(bus.output_time), 0);
      chk({tag, "_width"}, longint'(bus.output_width), 0);
      chk({tag, "_pileup"}, longint'(bus.output_pileup), 0);
   endtask

   initial begin
      reset          = 1'b1;
      bus.input_data = '0;
      bus.threshold  = 16'sd100;
      bus.holdoff    = '0;
      @(negedge clk);
      do_reset();
      chk_outputs_zero("rst");

      // basic pulse, peak at index 3, ends on 80 at index 6
      expect_pulse(300, 4, 3, 6, 1'b0);
      send(0); send(50); send(150); send(300);
      send(200); send(120); send(80); send(0);
      idle(3);
      chk("hold_amp", longint'(bus.output_amplitude), 300);
      chk("hold_width", longint'(bus.output_width), 4);

      // single sample above threshold: below MIN_WIDTH, discarded
      send(0); send(150); send(0);
      idle(3);

      // pile-up
      expect_pulse(300, 5, 1, 5, PU);
      send(150); send(300); send(200);
      send(250); send(120); send(50);
      idle(3);

      // holdoff=5: pulse at E+3 ignored, pulse at E+7 reported
      bus.holdoff = 8'd5;
      expect_pulse(300, 2, 1, 2, 1'b0);
      expect_pulse(220, 2, 10, 11, 1'b0);
      send(150); send(300); send(50);
      send(0); send(0); send(200); send(250); send(0);
      send(0); send(180); send(220); send(0);
      idle(7);
      bus.holdoff = '0;

      // negative threshold and samples
      send(-20); send(-20);
      bus.threshold = -16'sd10;
      expect_pulse(-3, 2, 2, 3, 1'b0);
      send(-20); send(-5); send(-3); send(-20);
      bus.threshold = 16'sd100;
      idle(3);

      // width saturation, equal samples keep the first stamp
      expect_pulse(500, 255, 0, 300, 1'b0);
      for (int i = 0; i < 300; i++) send(500);
      idle(4);

      // reset while in RISE aborts the pulse and restarts the stamp
      send(0); send(150); send(300);
      do_reset();
      chk_outputs_zero("rst_rise");
      expect_pulse(400, 2, 3, 4, 1'b0);
      send(0); send(0); send(120); send(400); send(90); send(0);
      idle(5);

      chk("pending_expected", longint'(sbq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
